// File: rtl/lemming_arena_model.sv
// Track environment for a two-state walking lemming: follows walk_left/walk_right,
// keeps the position between two walls and answers wall hits with one-cycle bump pulses.
module lemming_arena_model #(
  parameter int TRACK_LEN = 16,
  parameter int POS_W     = 4,
  parameter int START_POS = 8,
  parameter int STEP_DIV  = 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             enable,
  input  logic             walk_left,
  input  logic             walk_right,
  output logic             bump_left,
  output logic             bump_right,
  output logic [POS_W-1:0] pos,
  output logic [7:0]       bump_count,
  output logic             err_both
);

  localparam int               DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(TRACK_LEN - 1);
  localparam logic [POS_W-1:0] POS_MIN  = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [POS_W-1:0] POS_RST  = POS_W'(START_POS);

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    if (val == 8'hFF) begin
      return val;
    end else begin
      return val + 8'd1;
    end
  endfunction

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             bump_left_q, bump_left_d;
  logic             bump_right_q, bump_right_d;
  logic [7:0]       bump_count_q, bump_count_d;
  logic             err_both_q, err_both_d;
  logic             tick_s;
  logic             eval_s;

  // A tick landing on a bump pulse is swallowed so the lemming gets one edge to turn.
  assign tick_s = enable && (div_cnt_q == DIV_LAST);
  assign eval_s = tick_s && !bump_left_q && !bump_right_q;

  // Step divider: advances only while enabled, wraps after STEP_DIV enabled cycles.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (enable) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = {DIV_W{1'b0}};
      end else begin
        div_cnt_d = div_cnt_q + DIV_ONE;
      end
    end else begin
      div_cnt_d = div_cnt_q;
    end
  end

  // Movement, wall detection and error capture on an evaluated tick.
  always_comb begin
    pos_d        = pos_q;
    bump_left_d  = 1'b0;
    bump_right_d = 1'b0;
    bump_count_d = bump_count_q;
    err_both_d   = err_both_q;
    if (eval_s) begin
      case ({walk_left, walk_right})
        2'b10: begin
          if (pos_q != POS_MIN) begin
            pos_d = pos_q - POS_ONE;
          end else begin
            bump_left_d  = 1'b1;
            bump_count_d = sat_inc8(bump_count_q);
          end
        end
        2'b01: begin
          if (pos_q != POS_MAX) begin
            pos_d = pos_q + POS_ONE;
          end else begin
            bump_right_d = 1'b1;
            bump_count_d = sat_inc8(bump_count_q);
          end
        end
        2'b11: begin
          err_both_d = 1'b1;
        end
        default: begin
          pos_d = pos_q;
        end
      endcase
    end else begin
      pos_d = pos_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      div_cnt_q    <= {DIV_W{1'b0}};
      pos_q        <= POS_RST;
      bump_left_q  <= 1'b0;
      bump_right_q <= 1'b0;
      bump_count_q <= 8'd0;
      err_both_q   <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pos_q        <= pos_d;
      bump_left_q  <= bump_left_d;
      bump_right_q <= bump_right_d;
      bump_count_q <= bump_count_d;
      err_both_q   <= err_both_d;
    end
  end

  assign bump_left  = bump_left_q;
  assign bump_right = bump_right_q;
  assign pos        = pos_q;
  assign bump_count = bump_count_q;
  assign err_both   = err_both_q;

endmodule

// File: tb/tb_lemming_arena_model.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor pops and compares.
module tb_lemming_arena_model;

  logic       clk = 1'b0;
  logic       areset = 1'b0;
  logic       en_a = 1'b0, wl_drv = 1'b0, wr_drv = 1'b0, closed_mode = 1'b0;
  logic       en_b = 1'b0, wl_b = 1'b0, wr_b = 1'b0;
  logic       wl_a, wr_a;
  logic       bl_a, br_a, err_a, bl_b, br_b, err_b;
  logic [2:0] pos_a, pos_b;
  logic [7:0] cnt_a, cnt_b;
  logic       lem_right_q;

  always #5 clk = ~clk;

  lemming_arena_model #(.TRACK_LEN(8), .POS_W(3), .START_POS(4), .STEP_DIV(1)) dut_a (
    .clk(clk), .areset(areset), .enable(en_a), .walk_left(wl_a), .walk_right(wr_a),
    .bump_left(bl_a), .bump_right(br_a), .pos(pos_a), .bump_count(cnt_a), .err_both(err_a));

  lemming_arena_model #(.TRACK_LEN(8), .POS_W(3), .START_POS(4), .STEP_DIV(3)) dut_b (
    .clk(clk), .areset(areset), .enable(en_b), .walk_left(wl_b), .walk_right(wr_b),
    .bump_left(bl_b), .bump_right(br_b), .pos(pos_b), .bump_count(cnt_b), .err_both(err_b));

  // Two-state walking lemming, turns on the bump that faces it.
  always @(posedge clk or posedge areset) begin
    if (areset) lem_right_q <= 1'b0;
    else if (!lem_right_q && bl_a) lem_right_q <= 1'b1;
    else if (lem_right_q && br_a) lem_right_q <= 1'b0;
  end

  assign wl_a = closed_mode ? ~lem_right_q : wl_drv;
  assign wr_a = closed_mode ?  lem_right_q : wr_drv;

  typedef struct packed {
    logic        sel;
    logic [2:0]  pos;
    logic        bl;
    logic        br;
    logic [7:0]  cnt;
    logic        err;
    logic [15:0] id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mx;
  int   checks = 0;
  int   errors = 0;
  int   id_n = 0;
  logic [2:0] g_pos;
  logic       g_bl, g_br, g_err;
  logic [7:0] g_cnt;

  task automatic expect_out(input logic sel, input logic [2:0] p, input logic bl,
                            input logic br, input logic [7:0] c, input logic e);
    exp_t x;
    x.sel = sel; x.pos = p; x.bl = bl; x.br = br; x.cnt = c; x.err = e;
    x.id = 16'(id_n);
    id_n++;
    exp_q.push_back(x);
  endtask

  task automatic cyc(input logic sel, input logic [2:0] p, input logic bl,
                     input logic br, input logic [7:0] c, input logic e);
    expect_out(sel, p, bl, br, c, e);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic sel);
    @(negedge clk);
    expect_out(sel, 3'd4, 1'b0, 1'b0, 8'd0, 1'b0);
    #1 areset = 1'b1;
    #3 areset = 1'b0;
  endtask

  // Monitor: samples 1 time unit after every clock or reset edge.
  always begin
    @(posedge clk or posedge areset);
    #1;
    if (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      g_pos = mx.sel ? pos_b : pos_a;
      g_bl  = mx.sel ? bl_b  : bl_a;
      g_br  = mx.sel ? br_b  : br_a;
      g_cnt = mx.sel ? cnt_b : cnt_a;
      g_err = mx.sel ? err_b : err_a;
      checks++;
      if (g_pos !== mx.pos || g_bl !== mx.bl || g_br !== mx.br || g_cnt !== mx.cnt || g_err !== mx.err) begin
        errors++;
        $display("FAIL step_%0d dut%0d: got pos=%0d bl=%0d br=%0d cnt=%0d err=%0d, expected pos=%0d bl=%0d br=%0d cnt=%0d err=%0d",
                 mx.id, mx.sel, g_pos, g_bl, g_br, g_cnt, g_err, mx.pos, mx.bl, mx.br, mx.cnt, mx.err);
      end
    end
    if (closed_mode && !areset) begin
      checks++;
      if ((bl_a && br_a) || pos_a > 3'd7 || $isunknown(pos_a)) begin
        errors++;
        $display("FAIL loop_invariant: got pos=%0d bl=%0d br=%0d, expected pos in 0..7 and not both bumps", pos_a, bl_a, br_a);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state.
    do_reset(1'b0);

    // Open-loop walk_left into the left wall.
    en_a = 1'b1; wl_drv = 1'b1; wr_drv = 1'b0;
    cyc(1'b0, 3'd3, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b0, 3'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b0, 3'd1, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b0, 3'd0, 1'b1, 1'b0, 8'd1, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 8'd1, 1'b0);
    cyc(1'b0, 3'd0, 1'b1, 1'b0, 8'd2, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 8'd2, 1'b0);
    wl_drv = 1'b0;
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 8'd2, 1'b0);

    // Both walk inputs high for one tick: sticky error, no motion.
    do_reset(1'b0);
    wl_drv = 1'b1; wr_drv = 1'b1;
    cyc(1'b0, 3'd4, 1'b0, 1'b0, 8'd0, 1'b1);
    wl_drv = 1'b0;
    cyc(1'b0, 3'd5, 1'b0, 1'b0, 8'd0, 1'b1);
    wr_drv = 1'b0;
    cyc(1'b0, 3'd5, 1'b0, 1'b0, 8'd0, 1'b1);
    do_reset(1'b0);
    en_a = 1'b0;

    // STEP_DIV=3 instance: stepping, enable freeze, right wall.
    do_reset(1'b1);
    en_b = 1'b1; wr_b = 1'b1;
    cyc(1'b1, 3'd4, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 3'd4, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 3'd5, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 3'd5, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 3'd5, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 3'd6, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 3'd6, 1'b0, 1'b0, 8'd0, 1'b0);
    en_b = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 3'd6, 1'b0, 1'b0, 8'd0, 1'b0);
    en_b = 1'b1;
    cyc(1'b1, 3'd6, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 3'd7, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 3'd7, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 3'd7, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 3'd7, 1'b0, 1'b1, 8'd1, 1'b0);
    cyc(1'b1, 3'd7, 1'b0, 1'b0, 8'd1, 1'b0);
    en_b = 1'b0; wr_b = 1'b0;

    // Closed loop: wall hits land on edges 5 + 9k, alternating left/right.
    do_reset(1'b0);
    closed_mode = 1'b1; en_a = 1'b1;
    for (int n = 1; n <= 2300; n++) begin
      case (n)
        4:       expect_out(1'b0, 3'd0, 1'b0, 1'b0, 8'd0,   1'b0);
        5:       expect_out(1'b0, 3'd0, 1'b1, 1'b0, 8'd1,   1'b0);
        6:       expect_out(1'b0, 3'd0, 1'b0, 1'b0, 8'd1,   1'b0);
        13:      expect_out(1'b0, 3'd7, 1'b0, 1'b0, 8'd1,   1'b0);
        14:      expect_out(1'b0, 3'd7, 1'b0, 1'b1, 8'd2,   1'b0);
        15:      expect_out(1'b0, 3'd7, 1'b0, 1'b0, 8'd2,   1'b0);
        16:      expect_out(1'b0, 3'd6, 1'b0, 1'b0, 8'd2,   1'b0);
        2282:    expect_out(1'b0, 3'd7, 1'b0, 1'b1, 8'd254, 1'b0);
        2291:    expect_out(1'b0, 3'd0, 1'b1, 1'b0, 8'd255, 1'b0);
        2292:    expect_out(1'b0, 3'd0, 1'b0, 1'b0, 8'd255, 1'b0);
        2300:    expect_out(1'b0, 3'd7, 1'b0, 1'b1, 8'd255, 1'b0);
        default: ;
      endcase
      @(posedge clk);
      #2;
    end
    // Reset lands in the middle of the bump_right pulse.
    do_reset(1'b0);
    closed_mode = 1'b0; en_a = 1'b0;
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
